// File: rtl/shift_op_sequencer.sv
// rtl/shift_op_sequencer.sv - hardwired fetch/execute sequencer for reg-reg shift/rotate instructions
// Optional feature: define SHSEQ_ROTATE_EN to decode ROR/ROL; otherwise they are illegal.
module shift_op_sequencer #(
    parameter int NUM_REGS   = 16,
    parameter int REG_ADDR_W = 4,
    parameter int IR_W       = 32
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic                mem_ack,
    input  logic [IR_W-1:0]     ir,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Read,
    output logic [2:0]          alu_op,
    output logic                busy,
    output logic                done,
    output logic                illegal
);

    localparam int OPC_W   = 5;
    localparam int OPC_LSB = IR_W - OPC_W;
    localparam int RA_LSB  = OPC_LSB - REG_ADDR_W;
    localparam int RB_LSB  = RA_LSB - REG_ADDR_W;
    localparam int RC_LSB  = RB_LSB - REG_ADDR_W;

    localparam logic [REG_ADDR_W:0]   REG_LIMIT = (REG_ADDR_W + 1)'(NUM_REGS);
    localparam logic [NUM_REGS-1:0]   ONE_HOT0  = {{(NUM_REGS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5
    } state_t;

    state_t                state_q, state_d;
    logic [OPC_W-1:0]      opc_q;
    logic [REG_ADDR_W-1:0] ra_q, rb_q, rc_q;

    logic       opc_ok;
    logic       legal;
    logic [2:0] alu_dec;

    // Bits below the rc field carry no meaning for this instruction class.
    logic unused_ir;
    assign unused_ir = ^ir[RC_LSB-1:0];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            opc_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_T2) begin
                opc_q <= ir[OPC_LSB +: OPC_W];
                ra_q  <= ir[RA_LSB +: REG_ADDR_W];
                rb_q  <= ir[RB_LSB +: REG_ADDR_W];
                rc_q  <= ir[RC_LSB +: REG_ADDR_W];
            end
        end
    end

    always_comb begin
        opc_ok  = 1'b1;
        alu_dec = 3'b000;
        case (opc_q)
            5'b00101: alu_dec = 3'b001;
            5'b00110: alu_dec = 3'b010;
            5'b00111: alu_dec = 3'b011;
`ifdef SHSEQ_ROTATE_EN
            5'b01000: alu_dec = 3'b100;
            5'b01001: alu_dec = 3'b101;
`endif
            default:  opc_ok  = 1'b0;
        endcase
        legal = opc_ok
              && ({1'b0, ra_q} < REG_LIMIT)
              && ({1'b0, rb_q} < REG_LIMIT)
              && ({1'b0, rc_q} < REG_LIMIT);
    end

    // Moore decode: every strobe is a function of state_q and the latched fields only.
    always_comb begin
        state_d = state_q;
        Rout    = '0;
        Rin     = '0;
        PCout   = 1'b0;
        PCin    = 1'b0;
        IncPC   = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        Read    = 1'b0;
        alu_op  = 3'b000;
        busy    = (state_q != S_IDLE);
        done    = 1'b0;
        illegal = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_T0;
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = mem_ack ? S_T2 : S_T1W;
            end
            S_T1W: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                if (mem_ack) state_d = S_T2;
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                if (legal) begin
                    Rout    = ONE_HOT0 << rb_q;
                    Yin     = 1'b1;
                    state_d = S_T4;
                end else begin
                    illegal = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_T4: begin
                Rout    = ONE_HOT0 << rc_q;
                Zin     = 1'b1;
                alu_op  = alu_dec;
                state_d = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                Rin     = ONE_HOT0 << ra_q;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_op_sequencer.sv
// tb/tb_shift_op_sequencer.sv - self-checking bench for shift_op_sequencer
module tb_shift_op_sequencer;

    logic        clk = 1'b0;
    logic        clr, start, mem_ack;
    logic [31:0] ir;
    logic [15:0] Rout, Rin;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Read;
    logic [2:0]  alu_op;
    logic        busy, done, illegal;

    int checks = 0;
    int errors = 0;

`ifdef SHSEQ_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] rout;
        logic [15:0] rin;
        logic pcout, pcin, incpc, marin, mdrin, mdrout, irin, yin, zin, zlowout, read;
        logic [2:0] alu;
        logic busy, done, illegal;
    } obs_t;

    obs_t obs;
    assign obs = {Rout, Rin, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin,
                  Zlowout, Read, alu_op, busy, done, illegal};

    localparam int P_IDLE = 0, P_T0 = 1, P_T1 = 2, P_T1W = 3, P_T2 = 4,
                   P_T3 = 5, P_T3I = 6, P_T4 = 7, P_T5 = 8;

    shift_op_sequencer dut (
        .clk(clk), .clr(clr), .start(start), .mem_ack(mem_ack), .ir(ir),
        .Rout(Rout), .Rin(Rin), .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
        .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .Zin(Zin), .Zlowout(Zlowout), .Read(Read), .alu_op(alu_op),
        .busy(busy), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input obs_t e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    function automatic obs_t phase_out(int ph, int ra, int rb, int rc, int alu);
        obs_t        e = '0;
        logic [15:0] one = 16'd1;
        e.busy = (ph != P_IDLE);
        case (ph)
            P_T0:  begin e.pcout = 1; e.marin = 1; e.incpc = 1; e.zin = 1; end
            P_T1:  begin e.zlowout = 1; e.pcin = 1; e.read = 1; e.mdrin = 1; end
            P_T1W: begin e.read = 1; e.mdrin = 1; end
            P_T2:  begin e.mdrout = 1; e.irin = 1; end
            P_T3:  begin e.rout = one << rb; e.yin = 1; end
            P_T3I: e.illegal = 1;
            P_T4:  begin e.rout = one << rc; e.zin = 1; e.alu = 3'(alu); end
            P_T5:  begin e.zlowout = 1; e.rin = one << ra; e.done = 1; end
            default: ;
        endcase
        return e;
    endfunction

    // mode 0: single pulse; 1: random start/ir noise while busy; 2: start held (back-to-back)
    task automatic run(input logic [31:0] ir_v, input int nwait, input int mode,
                       input int abort_at, input string name);
        int opc = int'(ir_v[31:27]);
        int ra  = int'(ir_v[26:23]);
        int rb  = int'(ir_v[22:19]);
        int rc  = int'(ir_v[18:15]);
        bit legal_op = (opc >= 5 && opc <= 7) || (ROT && (opc == 8 || opc == 9));
        bit legal = legal_op && ra < 16 && rb < 16 && rc < 16;
        int alu = opc - 4;
        int ph[$];
        int abort_k = abort_at;
        ph.push_back(P_T0);
        ph.push_back(P_T1);
        for (int i = 0; i < nwait; i++) ph.push_back(P_T1W);
        ph.push_back(P_T2);
        if (legal) begin
            ph.push_back(P_T3); ph.push_back(P_T4); ph.push_back(P_T5);
        end else begin
            ph.push_back(P_T3I);
        end
        ph.push_back(P_IDLE);
        if (mode == 2) begin
            ph.push_back(P_T0);
            abort_k = ph.size() - 1;
        end
        @(negedge clk);
        ir = ir_v; start = 1'b1; mem_ack = 1'b0;
        for (int k = 0; k < ph.size(); k++) begin
            @(negedge clk);
            chk($sformatf("%s_c%0d", name, k), phase_out(ph[k], ra, rb, rc, alu));
            if (k == abort_k) begin
                #2 clr = 1'b0; start = 1'b0; mem_ack = 1'b0;
                #1 chk($sformatf("%s_abort", name), '0);
                @(negedge clk) clr = 1'b1;
                break;
            end
            mem_ack = (k >= nwait + 1);
            if (mode == 2) start = 1'b1;
            else if (mode == 1 && ph[k] != P_IDLE) start = 1'($urandom);
            else start = 1'b0;
            if (mode == 1 && (ph[k] == P_T3 || ph[k] == P_T4 || ph[k] == P_T5))
                ir = $urandom;
        end
        start = 1'b0;
    endtask

    initial begin
        clr = 1'b0; start = 1'b0; mem_ack = 1'b0; ir = '0;
        repeat (2) @(negedge clk);
        chk("reset", '0);
        clr = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", '0);

        #2 clr = 1'b0; start = 1'b1;
        #1 chk("clr_mid_idle", '0);
        @(negedge clk) clr = 1'b1; start = 1'b0;
        @(negedge clk) chk("idle_after_clr", '0);

        run(32'h28918000, 0, 0, -1, "shr_basic");
        run(32'h28918000, 3, 0, -1, "shr_wait3");
        run(32'h00000000, 0, 0, -1, "illegal_zero");
        run(32'h40918000, 0, 0, -1, "ror");
        run(32'h48918000, 1, 0, -1, "rol");
        run(32'h28918000, 5, 0, 3, "clr_in_t1w");
        run(32'h28918000, 0, 0, -1, "after_t1w_abort");
        run(32'h28918000, 0, 0, 4, "clr_in_t4");
        run(32'h38918000, 0, 0, -1, "shl_rerun");
        run(32'h30000000, 2, 0, -1, "shra_r0");
        run(32'h3FFF8000, 0, 0, -1, "shl_r15");
        run(32'h28918000, 0, 2, -1, "back_to_back");

        for (int n = 0; n < 24; n++) begin
            logic [4:0]  opc_r;
            logic [31:0] ir_r;
            opc_r = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'($urandom_range(5, 9));
            ir_r  = $urandom;
            ir_r[31:27] = opc_r;
            run(ir_r, $urandom_range(0, 3), 1, -1, $sformatf("rand%0d", n));
        end

        @(negedge clk) chk("final_idle", '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
